// File: rtl/sample_pkg.sv
// Shared types and constants for the sample serializer.
package sample_pkg;

  localparam int unsigned SampleW = 9;
  localparam int unsigned FrameN  = 8;

  // Slot index of the last sample in a default-sized frame.
  localparam logic [3:0] LAST_SLOT = 4'(FrameN - 1);

  typedef logic [SampleW-1:0] sample_t;
  typedef sample_t [FrameN-1:0] frame_t;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/sample_serializer_slot_select.sv
// Combinational N:1 sample mux; out-of-range selects return zero.
module slot_select #(
  parameter int unsigned W = 9,
  parameter int unsigned N = 8
) (
  input  logic [N-1:0][W-1:0] frame,
  input  logic [3:0]          sel,
  output logic [W-1:0]        sample
);

  logic [N-1:0][W-1:0] masked;
  logic [N:0][W-1:0]   acc;

  assign acc[0] = '0;

  for (genvar g = 0; g < N; g++) begin : gen_slot
    assign masked[g]  = (sel == 4'(g)) ? frame[g] : '0;
    assign acc[g + 1] = acc[g] | masked[g];
  end

  assign sample = acc[N];

endmodule

// File: rtl/sample_serializer.sv
// Parallel-to-serial frame unloader with shadow/active double buffering.
module sample_serializer
  import sample_pkg::*;
#(
  parameter int unsigned W = SampleW,
  parameter int unsigned N = FrameN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  input  logic [W-1:0] I4,
  input  logic [W-1:0] I5,
  input  logic [W-1:0] I6,
  input  logic [W-1:0] I7,
  output logic         ready,
  output logic [W-1:0] data_out,
  output logic         data_load,
  output logic [3:0]   count,
  output logic         busy
);

  localparam logic [3:0] LastIdx = 4'(N - 1);

  logic [7:0][W-1:0]   in_bus;
  logic [N-1:0][W-1:0] in_frame;

  assign in_bus = {I7, I6, I5, I4, I3, I2, I1, I0};

  // Slots beyond the eight physical inputs read as zero.
  for (genvar g = 0; g < N; g++) begin : gen_in
    if (g < 8) begin : gen_wired
      assign in_frame[g] = in_bus[g];
    end else begin : gen_zero
      assign in_frame[g] = '0;
    end
  end

  state_e              state_q, state_d;
  logic [N-1:0][W-1:0] shadow_q, shadow_d;
  logic [N-1:0][W-1:0] active_q, active_d;
  logic                shadow_full_q, shadow_full_d;
  logic [W-1:0]        data_out_q, data_out_d;
  logic                data_load_q, data_load_d;
  logic [3:0]          count_q, count_d;

  logic [W-1:0] active_next;
  logic [W-1:0] shadow_first;
  logic         accept;

  slot_select #(
    .W (W),
    .N (N)
  ) u_active_sel (
    .frame  (active_q),
    .sel    (count_q + 4'd1),
    .sample (active_next)
  );

  slot_select #(
    .W (W),
    .N (N)
  ) u_shadow_sel (
    .frame  (shadow_q),
    .sel    (4'd0),
    .sample (shadow_first)
  );

  // Shadow can only be written while empty, so accept never races a transfer.
  assign accept = valid && !shadow_full_q;

  // Next-state: frame acceptance, shadow-to-active transfer and slot stepping.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    shadow_full_d = shadow_full_q;
    data_out_d    = data_out_q;
    data_load_d   = 1'b0;
    count_d       = count_q;

    if (accept) begin
      shadow_d      = in_frame;
      shadow_full_d = 1'b1;
    end

    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
            data_out_d    = shadow_first;
            count_d       = 4'd0;
            data_load_d   = 1'b1;
            state_d       = StShift;
          end
        end
        StShift: begin
          if (count_q != LastIdx) begin
            count_d     = count_q + 4'd1;
            data_out_d  = active_next;
            data_load_d = 1'b1;
          end else if (shadow_full_q) begin
            // Chain straight into the pending frame without a bubble.
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
            data_out_d    = shadow_first;
            count_d       = 4'd0;
            data_load_d   = 1'b1;
          end else begin
            count_d = 4'd0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      active_q      <= '0;
      shadow_full_q <= 1'b0;
      data_out_q    <= '0;
      data_load_q   <= 1'b0;
      count_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      data_out_q    <= data_out_d;
      data_load_q   <= data_load_d;
      count_q       <= count_d;
    end
  end

  assign ready     = !shadow_full_q;
  assign busy      = (state_q == StShift);
  assign data_out  = data_out_q;
  assign data_load = data_load_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Directed self-checking bench for sample_serializer.
module tb_sample_serializer;
  import sample_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       valid;
  sample_t    ins [8];
  logic       ready;
  sample_t    data_out;
  logic       data_load;
  logic [3:0] count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  sample_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid     (valid),
    .I0        (ins[0]),
    .I1        (ins[1]),
    .I2        (ins[2]),
    .I3        (ins[3]),
    .I4        (ins[4]),
    .I5        (ins[5]),
    .I6        (ins[6]),
    .I7        (ins[7]),
    .ready     (ready),
    .data_out  (data_out),
    .data_load (data_load),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input logic [8:0] base, input bit inc);
    for (int i = 0; i < 8; i++) ins[i] = inc ? base + 9'(i) : base;
  endtask

  task automatic check_sample(input string tag, input logic [8:0] exp_data,
                              input logic [3:0] exp_count);
    check({tag, ".load"}, {31'd0, data_load}, 32'd1);
    check({tag, ".data"}, {23'd0, data_out}, {23'd0, exp_data});
    check({tag, ".count"}, {28'd0, count}, {28'd0, exp_count});
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    logic [8:0] exp_d;
    bit         hs;

    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    set_frame(9'h000, 1'b0);
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.ready", {31'd0, ready}, 32'd1);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.load", {31'd0, data_load}, 32'd0);
    check("rst.count", {28'd0, count}, 32'd0);
    check("rst.data", {23'd0, data_out}, 32'd0);

    // Single frame 001..008
    set_frame(9'h001, 1'b1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("single.ready_low", {31'd0, ready}, 32'd0);
    check("single.no_load_yet", {31'd0, data_load}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_sample("single", 9'h001 + 9'(k), 4'(k));
      if (k == 0) check("single.ready_back", {31'd0, ready}, 32'd1);
    end
    check("single.last_slot", {28'd0, count}, {28'd0, LAST_SLOT});
    tick();
    check("single.end_busy", {31'd0, busy}, 32'd0);
    check("single.end_load", {31'd0, data_load}, 32'd0);
    check("single.end_count", {28'd0, count}, 32'd0);
    check("single.end_hold", {23'd0, data_out}, 32'h008);

    // Back-to-back frames A then B
    set_frame(9'h100, 1'b1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        check("b2b.ready_rise", {31'd0, ready}, 32'd1);
        set_frame(9'h1F0, 1'b1);
        valid = 1'b1;
      end
      tick();
      valid = 1'b0;
      exp_d = (k < 8) ? 9'h100 + 9'(k) : 9'h1F0 + 9'(k - 8);
      check_sample("b2b", exp_d, 4'(k % 8));
    end
    tick();
    check("b2b.end_busy", {31'd0, busy}, 32'd0);
    check("b2b.end_load", {31'd0, data_load}, 32'd0);

    // Backpressure: third frame held on valid while two are in flight
    set_frame(9'h010, 1'b1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k == 1) begin
        set_frame(9'h020, 1'b1);
        valid = 1'b1;
      end
      if (k == 2) begin
        set_frame(9'h030, 1'b1);
        valid = 1'b1;
      end
      hs = valid && ready;
      tick();
      if (hs) valid = 1'b0;
      exp_d = 9'h010 + 9'(16 * (k / 8)) + 9'(k % 8);
      check_sample("bp", exp_d, 4'(k % 8));
      check("bp.ready", {31'd0, ready}, (k == 0 || k == 8 || k >= 16) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp.no_dup_load", {31'd0, data_load}, 32'd0);
      check("bp.no_dup_busy", {31'd0, busy}, 32'd0);
    end

    // Stall for 3 cycles with slot 4 on the output
    set_frame(9'h040, 1'b1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_sample("stall.pre", 9'h040 + 9'(k), 4'(k));
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall.load", {31'd0, data_load}, 32'd0);
      check("stall.count", {28'd0, count}, 32'd4);
      check("stall.data", {23'd0, data_out}, 32'h044);
      check("stall.busy", {31'd0, busy}, 32'd1);
    end
    en = 1'b1;
    for (int k = 5; k < 8; k++) begin
      tick();
      check_sample("stall.post", 9'h040 + 9'(k), 4'(k));
    end
    tick();
    check("stall.end_busy", {31'd0, busy}, 32'd0);

    // Reset at slot 3 with a shadow frame pending
    set_frame(9'h050, 1'b1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check_sample("mid.d0", 9'h050, 4'd0);
    set_frame(9'h060, 1'b1);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    check_sample("mid.d3", 9'h053, 4'd3);
    check("mid.shadow_full", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.ready", {31'd0, ready}, 32'd1);
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.count", {28'd0, count}, 32'd0);
    check("mid.data", {23'd0, data_out}, 32'd0);
    check("mid.load", {31'd0, data_load}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("mid.no_stale_load", {31'd0, data_load}, 32'd0);
      check("mid.no_stale_busy", {31'd0, busy}, 32'd0);
    end

    // Boundary values: all-ones frame followed by all-zeros frame
    set_frame(9'h1FF, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        set_frame(9'h000, 1'b0);
        valid = 1'b1;
      end
      tick();
      valid = 1'b0;
      check_sample("bound", (k < 8) ? 9'h1FF : 9'h000, 4'(k % 8));
    end
    tick();
    check("bound.end_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
